// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported unified instruction/data RAM between the IF
//   (fetch) and MEM (load/store) pipeline stages. Arbitrates with MEM
//   priority bounded by a fairness counter, sequences the RAM request/ack
//   handshake, returns read data with a one-cycle VALID pulse, and can
//   discard an in-flight fetch on a branch mispredict (FLUSH).
//
// Ports
//   CLK, RST_N                        clock, async active-low reset
//   IF_REQ/IF_ADDR                    fetch request (level) and address
//   IF_RDATA/IF_VALID                 fetched word, completion pulse
//   FLUSH                             discard any in-flight fetch
//   MEM_REQ/MEM_WE/MEM_ADDR/MEM_WDATA data request, store flag, addr, data
//   MEM_RDATA/MEM_VALID               load data, completion pulse
//   RAM_REQ/RAM_WE/RAM_ADDR/RAM_WDATA RAM request side (held until ack)
//   RAM_RDATA/RAM_ACK                 RAM response side
//   STALL_IF/STALL_MEM                per-stage stall toward the pipeline
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FAIR_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              IF_REQ,
    input  logic [ADDR_W-1:0] IF_ADDR,
    output logic [DATA_W-1:0] IF_RDATA,
    output logic              IF_VALID,
    input  logic              FLUSH,
    input  logic              MEM_REQ,
    input  logic              MEM_WE,
    input  logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [DATA_W-1:0] MEM_WDATA,
    output logic [DATA_W-1:0] MEM_RDATA,
    output logic              MEM_VALID,
    output logic              RAM_REQ,
    output logic              RAM_WE,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic [DATA_W-1:0] RAM_WDATA,
    input  logic [DATA_W-1:0] RAM_RDATA,
    input  logic              RAM_ACK,
    output logic              STALL_IF,
    output logic              STALL_MEM
);

    localparam int unsigned       CNT_W = $clog2(FAIR_LIMIT + 1);
    localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(FAIR_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        GRANT_IF,
        GRANT_MEM,
        RESP
    } state_e;

    state_e             state_q, state_d;
    logic               owner_if_q, owner_if_d;   // transaction belongs to IF
    logic               discard_q, discard_d;     // fetch flushed while in flight
    logic [CNT_W-1:0]   fair_cnt_q, fair_cnt_d;
    logic               ram_req_q, ram_req_d;
    logic               ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]  ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0]  if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]  mem_rdata_q, mem_rdata_d;
    logic               if_wins;

    // IF is forced through only once MEM has taken FAIR_LIMIT grants in a
    // row while a fetch was waiting.
    assign if_wins = IF_REQ && (!MEM_REQ || (fair_cnt_q == LIMIT));

    always_comb begin
        state_d     = state_q;
        owner_if_d  = owner_if_q;
        discard_d   = discard_q;
        fair_cnt_d  = fair_cnt_q;
        ram_req_d   = ram_req_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;

        case (state_q)
            IDLE: begin
                if (if_wins) begin
                    state_d     = GRANT_IF;
                    owner_if_d  = 1'b1;
                    ram_req_d   = 1'b1;
                    ram_we_d    = 1'b0;
                    ram_addr_d  = IF_ADDR;
                    ram_wdata_d = '0;
                    fair_cnt_d  = '0;
                end else if (MEM_REQ) begin
                    state_d     = GRANT_MEM;
                    owner_if_d  = 1'b0;
                    ram_req_d   = 1'b1;
                    ram_we_d    = MEM_WE;
                    ram_addr_d  = MEM_ADDR;
                    ram_wdata_d = MEM_WDATA;
                    if (!IF_REQ) begin
                        fair_cnt_d = '0;
                    end else if (fair_cnt_q != LIMIT) begin
                        fair_cnt_d = fair_cnt_q + 1'b1;
                    end
                end
            end
            GRANT_IF: begin
                if (FLUSH) begin
                    discard_d = 1'b1;
                end
                if (RAM_ACK) begin
                    ram_req_d = 1'b0;
                    state_d   = RESP;
                    // A flush in the ack cycle itself must also suppress the update.
                    if (!discard_q && !FLUSH) begin
                        if_rdata_d = RAM_RDATA;
                    end
                end
            end
            GRANT_MEM: begin
                if (RAM_ACK) begin
                    ram_req_d = 1'b0;
                    state_d   = RESP;
                    if (!ram_we_q) begin
                        mem_rdata_d = RAM_RDATA;
                    end
                end
            end
            RESP: begin
                state_d   = IDLE;
                discard_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            owner_if_q  <= 1'b0;
            discard_q   <= 1'b0;
            fair_cnt_q  <= '0;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_if_q  <= owner_if_d;
            discard_q   <= discard_d;
            fair_cnt_q  <= fair_cnt_d;
            ram_req_q   <= ram_req_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign IF_VALID  = (state_q == RESP) && owner_if_q && !discard_q;
    assign MEM_VALID = (state_q == RESP) && !owner_if_q;
    assign IF_RDATA  = if_rdata_q;
    assign MEM_RDATA = mem_rdata_q;
    assign RAM_REQ   = ram_req_q;
    assign RAM_WE    = ram_we_q;
    assign RAM_ADDR  = ram_addr_q;
    assign RAM_WDATA = ram_wdata_q;
    assign STALL_IF  = IF_REQ && !IF_VALID;
    assign STALL_MEM = MEM_REQ && !MEM_VALID;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed timing scenarios followed by a
// fairness run and a randomized run, all checked through a scoreboard.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned FL = 4;

    logic          CLK, RST_N;
    logic          IF_REQ, IF_VALID, FLUSH;
    logic [AW-1:0] IF_ADDR;
    logic [DW-1:0] IF_RDATA;
    logic          MEM_REQ, MEM_WE, MEM_VALID;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_WDATA, MEM_RDATA;
    logic          RAM_REQ, RAM_WE, RAM_ACK;
    logic [AW-1:0] RAM_ADDR;
    logic [DW-1:0] RAM_WDATA, RAM_RDATA;
    logic          STALL_IF, STALL_MEM;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FAIR_LIMIT(FL)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_RDATA(IF_RDATA), .IF_VALID(IF_VALID),
        .FLUSH(FLUSH),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_RDATA(MEM_RDATA), .MEM_VALID(MEM_VALID),
        .RAM_REQ(RAM_REQ), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR), .RAM_WDATA(RAM_WDATA),
        .RAM_RDATA(RAM_RDATA), .RAM_ACK(RAM_ACK),
        .STALL_IF(STALL_IF), .STALL_MEM(STALL_MEM)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        bit          is_store;
        logic [31:0] data;
    } mexp_t;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] if_q[$];
    mexp_t       mem_q[$];
    bit          grant_rec[$];
    bit          rec_en = 1'b0;
    logic [31:0] ram_mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] mem_last = '0;
    logic [31:0] if_last = '0;
    int          ram_wait_mode = 0;
    bit          spurious_ack = 1'b0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // Issue n MEM transactions; cont keeps MEM_REQ high back to back.
    task automatic mem_agent(input int n, input bit cont);
        bit ok;
        for (int i = 0; i < n; i++) begin
            mexp_t e;
            step();
            MEM_REQ   = 1'b1;
            MEM_WE    = 1'($urandom_range(0, 1));
            MEM_ADDR  = 32'($urandom_range(0, 63)) << 2;
            MEM_WDATA = $urandom;
            e.is_store = MEM_WE;
            if (MEM_WE) begin
                e.data = mem_last;
                ref_mem[MEM_ADDR] = MEM_WDATA;
            end else begin
                e.data   = ref_read(MEM_ADDR);
                mem_last = e.data;
            end
            mem_q.push_back(e);
            ok = 1'b0;
            for (int k = 0; k < 200; k++) begin
                smp();
                if (MEM_VALID) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                vectors++;
                miscompares++;
                $display("FAIL mem_timeout: no MEM_VALID within 200 cycles, addr %h", MEM_ADDR);
            end
            if (!cont) begin
                step();
                MEM_REQ = 1'b0;
                repeat ($urandom_range(0, 3)) step();
            end
        end
        step();
        MEM_REQ = 1'b0;
    endtask

    // Issue n fetches; with do_flush, FLUSH toggles randomly while no fetch
    // is outstanding, where it must have no effect.
    task automatic if_agent(input int n, input bit cont, input bit do_flush);
        bit ok;
        for (int i = 0; i < n; i++) begin
            step();
            FLUSH   = 1'b0;
            IF_REQ  = 1'b1;
            IF_ADDR = 32'h100 + (32'($urandom_range(0, 63)) << 2);
            if_last = init_word(IF_ADDR);
            if_q.push_back(if_last);
            ok = 1'b0;
            for (int k = 0; k < 200; k++) begin
                smp();
                if (IF_VALID) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                vectors++;
                miscompares++;
                $display("FAIL if_timeout: no IF_VALID within 200 cycles, addr %h", IF_ADDR);
            end
            if (!cont) begin
                step();
                IF_REQ = 1'b0;
                repeat ($urandom_range(0, 3)) begin
                    if (do_flush) FLUSH = 1'b1 & 1'($urandom_range(0, 1));
                    step();
                end
                FLUSH = 1'b0;
            end
        end
        step();
        IF_REQ = 1'b0;
        FLUSH  = 1'b0;
    endtask

    initial begin
        logic [31:0] prev;
        bit          ok;
        int          cnt;
        bit          exp_if;

        RST_N = 1'b1; IF_REQ = 1'b0; IF_ADDR = '0; FLUSH = 1'b0;
        MEM_REQ = 1'b0; MEM_WE = 1'b0; MEM_ADDR = '0; MEM_WDATA = '0;
        RAM_ACK = 1'b0; RAM_RDATA = '0;

        fork
            // RAM model: ack after a per-transaction wait count.
            begin : ram_model
                bit busy;
                int wcnt;
                busy = 1'b0;
                wcnt = 0;
                forever begin
                    @(posedge CLK);
                    #1;
                    if (!RST_N) begin
                        RAM_ACK = 1'b0;
                        busy    = 1'b0;
                    end else if (RAM_ACK) begin
                        RAM_ACK = 1'b0;
                    end else if (spurious_ack && !RAM_REQ) begin
                        RAM_ACK      = 1'b1;
                        RAM_RDATA    = $urandom;
                        spurious_ack = 1'b0;
                    end else if (RAM_REQ) begin
                        if (!busy) begin
                            busy = 1'b1;
                            wcnt = (ram_wait_mode < 0) ? int'($urandom_range(0, 3)) : ram_wait_mode;
                        end
                        if (wcnt == 0) begin
                            RAM_ACK = 1'b1;
                            busy    = 1'b0;
                            if (RAM_WE) begin
                                ram_mem[RAM_ADDR] = RAM_WDATA;
                                RAM_RDATA = $urandom;
                            end else begin
                                RAM_RDATA = ram_mem.exists(RAM_ADDR) ? ram_mem[RAM_ADDR] : init_word(RAM_ADDR);
                            end
                        end else begin
                            wcnt--;
                        end
                    end
                end
            end
            // Scoreboard monitor and grant recorder.
            begin : monitor
                logic [31:0] ie;
                mexp_t       me;
                bit          req_prev;
                req_prev = 1'b0;
                forever begin
                    @(negedge CLK);
                    if (RST_N) begin
                        if (IF_VALID) begin
                            if (if_q.size() == 0) begin
                                vectors++;
                                miscompares++;
                                $display("FAIL if_unexpected: IF_VALID with nothing outstanding, IF_RDATA %h at %0t", IF_RDATA, $time);
                            end else begin
                                ie = if_q.pop_front();
                                chk32("if_rdata", IF_RDATA, ie);
                            end
                        end
                        if (MEM_VALID) begin
                            if (mem_q.size() == 0) begin
                                vectors++;
                                miscompares++;
                                $display("FAIL mem_unexpected: MEM_VALID with nothing outstanding, MEM_RDATA %h at %0t", MEM_RDATA, $time);
                            end else begin
                                me = mem_q.pop_front();
                                chk32(me.is_store ? "mem_rdata_store" : "mem_rdata_load", MEM_RDATA, me.data);
                            end
                        end
                        if (rec_en && RAM_REQ && !req_prev) grant_rec.push_back(RAM_ADDR >= 32'h100);
                    end
                    req_prev = RAM_REQ;
                end
            end
        join_none

        // Reset state
        #2 RST_N = 1'b0;
        #1;
        chk1("rst_ram_req", RAM_REQ, 1'b0);
        chk1("rst_if_valid", IF_VALID, 1'b0);
        chk1("rst_mem_valid", MEM_VALID, 1'b0);
        chk32("rst_if_rdata", IF_RDATA, 32'h0);
        chk32("rst_mem_rdata", MEM_RDATA, 32'h0);
        chk32("rst_ram_addr", RAM_ADDR, 32'h0);
        repeat (2) smp();
        RST_N = 1'b1;
        repeat (2) step();

        // Single zero-wait load at 0x40
        ram_wait_mode = 0;
        ram_mem[32'h40] = 32'hDEADBEEF;
        ref_mem[32'h40] = 32'hDEADBEEF;
        step();
        MEM_REQ = 1'b1; MEM_WE = 1'b0; MEM_ADDR = 32'h40;
        mem_q.push_back('{1'b0, 32'hDEADBEEF});
        mem_last = 32'hDEADBEEF;
        smp();
        chk1("ld_c0_stall", STALL_MEM, 1'b1);
        chk1("ld_c0_ramreq", RAM_REQ, 1'b0);
        step(); smp();
        chk1("ld_c1_ramreq", RAM_REQ, 1'b1);
        chk32("ld_c1_addr", RAM_ADDR, 32'h40);
        chk1("ld_c1_we", RAM_WE, 1'b0);
        chk1("ld_c1_stall", STALL_MEM, 1'b1);
        step(); smp();
        chk1("ld_c2_valid", MEM_VALID, 1'b1);
        chk1("ld_c2_stall", STALL_MEM, 1'b0);
        step();
        MEM_REQ = 1'b0;
        smp();
        chk1("ld_c3_valid", MEM_VALID, 1'b0);

        // Store 0x12345678 to 0x80
        step();
        MEM_REQ = 1'b1; MEM_WE = 1'b1; MEM_ADDR = 32'h80; MEM_WDATA = 32'h12345678;
        mem_q.push_back('{1'b1, 32'hDEADBEEF});
        ref_mem[32'h80] = 32'h12345678;
        step(); smp();
        chk1("st_c1_we", RAM_WE, 1'b1);
        chk32("st_c1_addr", RAM_ADDR, 32'h80);
        chk32("st_c1_wdata", RAM_WDATA, 32'h12345678);
        step(); smp();
        chk1("st_c2_valid", MEM_VALID, 1'b1);
        step();
        MEM_REQ = 1'b0; MEM_WE = 1'b0;

        // Fetch at 0x100 with three RAM wait states
        ram_wait_mode = 3;
        step();
        IF_REQ = 1'b1; IF_ADDR = 32'h100;
        if_last = init_word(32'h100);
        if_q.push_back(if_last);
        for (int c = 1; c <= 4; c++) begin
            step(); smp();
            chk1("ws_ramreq", RAM_REQ, 1'b1);
            chk32("ws_addr", RAM_ADDR, 32'h100);
            chk1("ws_valid_early", IF_VALID, 1'b0);
            chk1("ws_stall", STALL_IF, 1'b1);
        end
        step(); smp();
        chk1("ws_c5_valid", IF_VALID, 1'b1);
        chk1("ws_c5_stall", STALL_IF, 1'b0);
        chk1("ws_c5_ramreq", RAM_REQ, 1'b0);
        step();
        IF_REQ = 1'b0;

        // Flush in the cycle after the grant, ack two cycles later
        ram_wait_mode = 2;
        prev = if_last;
        step();
        IF_REQ = 1'b1; IF_ADDR = 32'h104;
        step();
        FLUSH = 1'b1;
        smp();
        chk32("fl_c1_addr", RAM_ADDR, 32'h104);
        step();
        FLUSH = 1'b0;
        IF_ADDR = 32'h108;
        if_last = init_word(32'h108);
        if_q.push_back(if_last);
        for (int c = 2; c <= 5; c++) begin
            if (c > 2) step();
            smp();
            chk1("fl_no_valid", IF_VALID, 1'b0);
            chk1("fl_stall", STALL_IF, 1'b1);
            chk32("fl_rdata_held", IF_RDATA, prev);
        end
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            smp();
            if (IF_VALID) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL fl_refetch_timeout: fetch after flush never completed");
        end
        step();
        IF_REQ = 1'b0;

        // Reset in the middle of a MEM access
        ram_wait_mode = 5;
        step();
        MEM_REQ = 1'b1; MEM_WE = 1'b0; MEM_ADDR = 32'h44;
        step(); step();
        #2 RST_N = 1'b0;
        #1;
        chk1("rm_ramreq", RAM_REQ, 1'b0);
        chk1("rm_ramwe", RAM_WE, 1'b0);
        chk32("rm_ramaddr", RAM_ADDR, 32'h0);
        chk1("rm_memvalid", MEM_VALID, 1'b0);
        chk32("rm_memrdata", MEM_RDATA, 32'h0);
        chk32("rm_ifrdata", IF_RDATA, 32'h0);
        MEM_REQ = 1'b0;
        mem_q.delete();
        if_q.delete();
        mem_last = '0;
        if_last = '0;
        smp();
        RST_N = 1'b1;
        spurious_ack = 1'b1;
        repeat (6) step();
        smp();
        chk1("rm_idle_ramreq", RAM_REQ, 1'b0);
        chk32("rm_idle_memrdata", MEM_RDATA, 32'h0);

        // Fairness: both requesters continuously busy
        ram_wait_mode = 0;
        rec_en = 1'b1;
        fork
            mem_agent(14, 1'b1);
            if_agent(3, 1'b1, 1'b0);
        join
        rec_en = 1'b0;
        if (grant_rec.size() < 10) begin
            vectors++;
            miscompares++;
            $display("FAIL fair_count: only %0d grants recorded, need 10", grant_rec.size());
        end else begin
            cnt = 0;
            for (int i = 0; i < 10; i++) begin
                exp_if = (cnt == FL);
                cnt = exp_if ? 0 : ((cnt + 1 > FL) ? FL : cnt + 1);
                chk1("fair_order", grant_rec[i], exp_if);
            end
        end

        // Randomized traffic
        ram_wait_mode = -1;
        repeat (3) step();
        fork
            mem_agent(40, 1'b0);
            if_agent(40, 1'b1 & 1'b0, 1'b1);
        join
        repeat (5) step();
        chk32("if_pending", 32'(if_q.size()), 32'd0);
        chk32("mem_pending", 32'(mem_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
